// File: rtl/cp0_exc_ctrl_if.sv
// WB-boundary bundle between the pipeline/CP0/fetch side (master) and the
// exception commit controller (slave).
interface cp0_exc_ctrl_if #(
    parameter int unsigned NUM_INT = 8
);
    logic               wb_valid;
    logic [31:0]        wb_pc;
    logic               wb_bd_in;
    logic [6:0]         wb_flags;
    logic [31:0]        wb_data_addr;
    logic               wb_is_eret;
    logic [NUM_INT-1:0] int_req;
    logic               status_ie;
    logic               status_exl;
    logic [31:0]        cp0_epc;
    logic               wb_ex;
    logic [4:0]         wb_excode;
    logic               wb_bd;
    logic [31:0]        wb_badvaddr;
    logic               eret_flush;
    logic               commit_en;
    logic               flush;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               redirect_ready;
    logic               busy;

    modport master (
        output wb_valid, wb_pc, wb_bd_in, wb_flags, wb_data_addr, wb_is_eret,
               int_req, status_ie, status_exl, cp0_epc, redirect_ready,
        input  wb_ex, wb_excode, wb_bd, wb_badvaddr, eret_flush, commit_en,
               flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  wb_valid, wb_pc, wb_bd_in, wb_flags, wb_data_addr, wb_is_eret,
               int_req, status_ie, status_exl, cp0_epc, redirect_ready,
        output wb_ex, wb_excode, wb_bd, wb_badvaddr, eret_flush, commit_en,
               flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt/ERET commit controller at the WB boundary: decides
// commit vs. trap each cycle and runs the redirect handshake with fetch.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input logic           clk,
    input logic           reset,
    cp0_exc_ctrl_if.slave bus
);
    typedef enum logic {IDLE, REDIRECT} state_e;

    state_e      state_q, state_d;
    logic        int_pend_q, int_pend_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        idle;
    logic        event_hit;
    logic        take_ex;
    logic        take_eret;
    logic [4:0]  excode;
    logic [31:0] badvaddr;

    assign idle      = (state_q == IDLE);
    assign event_hit = int_pend_q | (|bus.wb_flags);
    assign take_ex   = idle & bus.wb_valid & event_hit;
    assign take_eret = idle & bus.wb_valid & ~event_hit & bus.wb_is_eret;

    // Fixed priority; the interrupt outranks every synchronous exception.
    always_comb begin
        excode   = '0;
        badvaddr = '0;
        if (int_pend_q) begin
            excode = 5'd0;
        end else if (bus.wb_flags[0]) begin
            excode   = 5'd4;
            badvaddr = bus.wb_pc;
        end else if (bus.wb_flags[1]) begin
            excode = 5'd10;
        end else if (bus.wb_flags[2]) begin
            excode = 5'd12;
        end else if (bus.wb_flags[3]) begin
            excode = 5'd8;
        end else if (bus.wb_flags[4]) begin
            excode = 5'd9;
        end else if (bus.wb_flags[5]) begin
            excode   = 5'd4;
            badvaddr = bus.wb_data_addr;
        end else if (bus.wb_flags[6]) begin
            excode   = 5'd5;
            badvaddr = bus.wb_data_addr;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        int_pend_d    = (|bus.int_req) & bus.status_ie & ~bus.status_exl;
        if (idle) begin
            if (take_ex) begin
                state_d       = REDIRECT;
                redirect_pc_d = EXC_VECTOR;
            end else if (take_eret) begin
                state_d       = REDIRECT;
                redirect_pc_d = bus.cp0_epc;
            end
        end else if (bus.redirect_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            int_pend_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            int_pend_q    <= int_pend_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.wb_ex          = take_ex;
    assign bus.wb_excode      = take_ex ? excode : 5'd0;
    assign bus.wb_bd          = take_ex & bus.wb_bd_in;
    assign bus.wb_badvaddr    = take_ex ? badvaddr : 32'd0;
    assign bus.eret_flush     = take_eret;
    assign bus.commit_en      = idle & bus.wb_valid & ~event_hit & ~bus.wb_is_eret;
    assign bus.flush          = take_ex | take_eret | ~idle;
    assign bus.redirect_valid = ~idle;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.busy           = ~idle;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: commit, exception priority, interrupt
// latency, ERET, redirect handshake and reset during redirect.
module tb_cp0_exc_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    cp0_exc_ctrl_if #(.NUM_INT(8)) ifc ();

    cp0_exc_ctrl #(.EXC_VECTOR(32'hBFC00380)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {wb_ex, eret_flush, commit_en, flush, redirect_valid, busy}
    logic [5:0] ctl;
    assign ctl = {ifc.wb_ex, ifc.eret_flush, ifc.commit_en, ifc.flush,
                  ifc.redirect_valid, ifc.busy};

    task automatic clear_inputs();
        ifc.wb_valid       = 1'b0;
        ifc.wb_pc          = '0;
        ifc.wb_bd_in       = 1'b0;
        ifc.wb_flags       = '0;
        ifc.wb_data_addr   = '0;
        ifc.wb_is_eret     = 1'b0;
        ifc.int_req        = '0;
        ifc.status_ie      = 1'b0;
        ifc.status_exl     = 1'b0;
        ifc.cp0_epc        = '0;
        ifc.redirect_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic leave_redirect();
        ifc.wb_valid       = 1'b0;
        ifc.wb_flags       = '0;
        ifc.wb_is_eret     = 1'b0;
        ifc.redirect_ready = 1'b1;
        tick();
        ifc.redirect_ready = 1'b0;
        #1;
        total++;
        if (ifc.busy !== 1'b0) begin
            bad++;
            $display("FAIL leave_redirect busy got=%b exp=0", ifc.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        total++;
        if (ctl !== 6'b000000) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=000000", ctl);
        end
        total++;
        if (ifc.redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_rpc got=%h exp=00000000", ifc.redirect_pc);
        end
        reset = 1'b0;
    endtask

    task automatic test_commit();
        ifc.wb_valid = 1'b1;
        #1;
        total++;
        if (ctl !== 6'b001000) begin
            bad++;
            $display("FAIL commit_ctl got=%b exp=001000", ctl);
        end
        tick();
        ifc.wb_valid = 1'b0;
        #1;
        total++;
        if (ctl !== 6'b000000) begin
            bad++;
            $display("FAIL bubble_ctl got=%b exp=000000", ctl);
        end
    endtask

    task automatic test_exception();
        ifc.wb_valid = 1'b1;
        ifc.wb_flags = 7'b0000100;
        ifc.wb_pc    = 32'hBFC01000;
        ifc.wb_bd_in = 1'b1;
        #1;
        total++;
        if ({ctl, ifc.wb_excode, ifc.wb_bd, ifc.wb_badvaddr} !==
            {6'b100100, 5'd12, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL ov_event got ctl=%b code=%0d bd=%b bva=%h exp ctl=100100 code=12 bd=1 bva=00000000",
                     ctl, ifc.wb_excode, ifc.wb_bd, ifc.wb_badvaddr);
        end
        tick();
        // Still presenting a flagged instruction: REDIRECT must ignore it.
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({ctl, ifc.redirect_pc} !== {6'b000111, 32'hBFC00380}) begin
                bad++;
                $display("FAIL redirect_hold[%0d] got ctl=%b rpc=%h exp ctl=000111 rpc=bfc00380",
                         i, ctl, ifc.redirect_pc);
            end
            tick();
        end
        ifc.redirect_ready = 1'b1;
        ifc.wb_flags       = '0;
        ifc.wb_bd_in       = 1'b0;
        #1;
        total++;
        if (ctl !== 6'b000111) begin
            bad++;
            $display("FAIL redirect_accept got=%b exp=000111", ctl);
        end
        tick();
        ifc.redirect_ready = 1'b0;
        #1;
        total++;
        if (ctl !== 6'b001000) begin
            bad++;
            $display("FAIL after_handshake got=%b exp=001000", ctl);
        end
        ifc.wb_valid = 1'b0;
    endtask

    task automatic test_priority();
        logic [6:0]  flags [7] = '{7'b1000001, 7'b0000110, 7'b0011000,
                                   7'b0010000, 7'b0100000, 7'b1000000,
                                   7'b1100000};
        logic [4:0]  code  [7] = '{5'd4, 5'd10, 5'd8, 5'd9, 5'd4, 5'd5, 5'd4};
        logic [31:0] bva   [7] = '{32'h00000003, 32'h0, 32'h0, 32'h0,
                                   32'h00001002, 32'h00001002, 32'h00001002};
        for (int i = 0; i < 7; i++) begin
            ifc.wb_valid     = 1'b1;
            ifc.wb_flags     = flags[i];
            ifc.wb_pc        = 32'h00000003;
            ifc.wb_data_addr = 32'h00001002;
            #1;
            total++;
            if ({ifc.wb_ex, ifc.wb_excode, ifc.wb_badvaddr} !== {1'b1, code[i], bva[i]}) begin
                bad++;
                $display("FAIL prio[%0d] got ex=%b code=%0d bva=%h exp ex=1 code=%0d bva=%h",
                         i, ifc.wb_ex, ifc.wb_excode, ifc.wb_badvaddr, code[i], bva[i]);
            end
            tick();
            leave_redirect();
        end
    endtask

    task automatic test_interrupt();
        // Interrupt while IE=0 is not taken.
        ifc.int_req   = 8'h80;
        ifc.status_ie = 1'b0;
        tick();
        ifc.wb_valid = 1'b1;
        #1;
        total++;
        if (ctl !== 6'b001000) begin
            bad++;
            $display("FAIL int_masked got=%b exp=001000", ctl);
        end
        ifc.wb_valid  = 1'b0;
        ifc.status_ie = 1'b1;
        #1;
        total++;
        if (ifc.wb_ex !== 1'b0) begin
            bad++;
            $display("FAIL int_latency got=%b exp=0", ifc.wb_ex);
        end
        tick();
        ifc.wb_valid = 1'b1;
        ifc.wb_flags = 7'b0001000;
        #1;
        total++;
        if ({ifc.wb_ex, ifc.wb_excode, ifc.wb_badvaddr} !== {1'b1, 5'd0, 32'h0}) begin
            bad++;
            $display("FAIL int_vs_sys got ex=%b code=%0d bva=%h exp ex=1 code=0 bva=00000000",
                     ifc.wb_ex, ifc.wb_excode, ifc.wb_badvaddr);
        end
        tick();
        ifc.status_exl = 1'b1;
        #1;
        total++;
        if ({ifc.wb_ex, ifc.busy} !== 2'b01) begin
            bad++;
            $display("FAIL int_single got ex,busy=%b exp=01", {ifc.wb_ex, ifc.busy});
        end
        leave_redirect();
        ifc.wb_valid = 1'b1;
        #1;
        total++;
        if (ctl !== 6'b001000) begin
            bad++;
            $display("FAIL int_cleared_by_exl got=%b exp=001000", ctl);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_eret();
        ifc.cp0_epc    = 32'hBFC00420;
        ifc.wb_valid   = 1'b1;
        ifc.wb_is_eret = 1'b1;
        #1;
        total++;
        if (ctl !== 6'b010100) begin
            bad++;
            $display("FAIL eret_event got=%b exp=010100", ctl);
        end
        tick();
        ifc.wb_valid       = 1'b0;
        ifc.wb_is_eret     = 1'b0;
        ifc.redirect_ready = 1'b1;
        #1;
        total++;
        if ({ctl, ifc.redirect_pc} !== {6'b000111, 32'hBFC00420}) begin
            bad++;
            $display("FAIL eret_redirect got ctl=%b rpc=%h exp ctl=000111 rpc=bfc00420",
                     ctl, ifc.redirect_pc);
        end
        tick();
        ifc.redirect_ready = 1'b0;
        ifc.wb_valid       = 1'b1;
        #1;
        total++;
        if (ctl !== 6'b001000) begin
            bad++;
            $display("FAIL eret_back_to_back got=%b exp=001000", ctl);
        end
        // ERET carrying RI: exception wins, no eret_flush.
        ifc.wb_is_eret = 1'b1;
        ifc.wb_flags   = 7'b0000010;
        #1;
        total++;
        if ({ctl, ifc.wb_excode} !== {6'b100100, 5'd10}) begin
            bad++;
            $display("FAIL eret_with_flag got ctl=%b code=%0d exp ctl=100100 code=10",
                     ctl, ifc.wb_excode);
        end
        tick();
        leave_redirect();
    endtask

    task automatic test_reset_in_redirect();
        ifc.wb_valid = 1'b1;
        ifc.wb_flags = 7'b0001000;
        #1;
        total++;
        if ({ifc.wb_ex, ifc.wb_excode} !== {1'b1, 5'd8}) begin
            bad++;
            $display("FAIL sys_event got ex=%b code=%0d exp ex=1 code=8", ifc.wb_ex, ifc.wb_excode);
        end
        tick();
        ifc.wb_valid = 1'b0;
        ifc.wb_flags = '0;
        reset        = 1'b1;
        #1;
        total++;
        if (ifc.busy !== 1'b1) begin
            bad++;
            $display("FAIL sync_reset_busy got=%b exp=1", ifc.busy);
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({ctl, ifc.redirect_pc} !== {6'b000000, 32'h0}) begin
            bad++;
            $display("FAIL reset_in_redirect got ctl=%b rpc=%h exp ctl=000000 rpc=00000000",
                     ctl, ifc.redirect_pc);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_commit();
        test_exception();
        test_priority();
        test_interrupt();
        test_eret();
        test_reset_in_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception/interrupt commit controller at the WB boundary of the 5-stage MIPS pipeline.
- Each cycle it decides whether the instruction in WB commits, takes an exception or interrupt, or executes ERET.
- It drives the CP0 register file's event inputs (wb_ex, wb_excode, wb_bd, wb_badvaddr, eret_flush), flushes the pipeline, and runs the redirect handshake with fetch.

Parameters:
EXC_VECTOR  32'hBFC00380  exception entry PC (BEV=1)
NUM_INT  8  width of the int_req vector

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wb_valid  in  1  valid instruction in WB this cycle
wb_pc  in  32  PC of WB instruction
wb_bd_in  in  1  WB instruction is in a delay slot
wb_flags  in  7  exception flags: [0]AdEL-fetch [1]RI [2]Ov [3]Sys [4]Bp [5]AdEL-data [6]AdES
wb_data_addr  in  32  load/store effective address
wb_is_eret  in  1  WB instruction is ERET
int_req  in  NUM_INT  status_im & cause_ip from CP0
status_ie  in  1  CP0 Status.IE
status_exl  in  1  CP0 Status.EXL
cp0_epc  in  32  CP0 EPC value
wb_ex  out  1  exception-taken pulse to CP0
wb_excode  out  5  ExcCode to CP0
wb_bd  out  1  BD to CP0
wb_badvaddr  out  32  BadVAddr to CP0
eret_flush  out  1  ERET pulse to CP0
commit_en  out  1  WB may write GPR/HI/LO/CP0 (mtc0)
flush  out  1  kill all instructions in IF..WB
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts redirect
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, int_pend_q=0, redirect_pc_q=0. All outputs 0 except redirect_pc=0.
- int_pend_q is registered every cycle as (|int_req) & status_ie & ~status_exl. This gives one cycle of sampling latency.
- State IDLE, wb_valid=1, event = int_pend_q | (|wb_flags). Cycle T, all combinational:
  - wb_ex=1, commit_en=0, flush=1.
  - wb_bd = wb_bd_in.
  - wb_excode by fixed priority: Int(0) > AdEL-fetch(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdEL-data(4) > AdES(5).
  - wb_badvaddr: wb_pc for AdEL-fetch; wb_data_addr for AdEL-data/AdES; 0 otherwise (including Int).
  - Register redirect_pc_q = EXC_VECTOR and go to REDIRECT.
- State IDLE, wb_valid=1, no event, wb_is_eret=1. Cycle T:
  - eret_flush=1, commit_en=0, flush=1.
  - Register redirect_pc_q = cp0_epc and go to REDIRECT.
- ERET carrying flags or arriving with int_pend_q=1: the exception path wins and eret_flush=0.
- State IDLE, wb_valid=1, no event, not ERET: commit_en=1, all event outputs 0.
- State IDLE, wb_valid=0: commit_en=0, no event. An interrupt stays pending (int_pend_q) until a valid WB instruction arrives.
- wb_ex and eret_flush are at most one cycle per event and never assert together.
- State REDIRECT:
  - redirect_valid=1, redirect_pc=redirect_pc_q, held stable until accepted.
  - flush=1, busy=1, commit_en=0.
  - wb_valid, wb_flags and int_pend_q are ignored; no wb_ex or eret_flush.
  - redirect_valid & redirect_ready → IDLE next cycle.
  - If fetch is ready in the first REDIRECT cycle (T+1), the controller is in IDLE at T+2.
- A stale int_pend_q=1 at T+1, sampled before EXL was set, is harmless because REDIRECT ignores it. By IDLE, status_exl=1 clears it.
- redirect_pc is driven with redirect_pc_q at all times; it is meaningful only while redirect_valid=1.
- Reset asserted during REDIRECT: next cycle IDLE and redirect_valid=0. No event is re-issued.
- Back-to-back: the instruction that reaches WB in the cycle after the handshake is evaluated normally. It is new-path, because flush killed the old path.

Test Plan:
1. Reset, then wb_valid=1, wb_flags=0, wb_is_eret=0 → commit_en=1, wb_ex=0, flush=0, busy=0.
2. wb_valid=1, wb_flags=7'b0000100 (Ov), wb_pc=0xBFC01000, wb_bd_in=1 → at T: wb_ex=1, wb_excode=12, wb_bd=1, wb_badvaddr=0, flush=1, commit_en=0. At T+1: redirect_valid=1, redirect_pc=0xBFC00380. With redirect_ready=0 for 3 cycles, then 1 → IDLE the cycle after the handshake.
3. wb_flags=7'b1000001 (AdEL-fetch+AdES), wb_pc=0x00000003, wb_data_addr=0x00001002 → wb_excode=4, wb_badvaddr=0x00000003.
4. int_req=8'h80, status_ie=1, status_exl=0 for 1 cycle with wb_valid=0, then wb_valid=1 with wb_flags=7'b0001000 (Sys) → wb_excode=0 (Int beats Sys), wb_ex=1 single cycle.
5. cp0_epc=0xBFC00420, wb_valid=1, wb_is_eret=1, no flags/int → eret_flush=1, wb_ex=0, commit_en=0. Then redirect_pc=0xBFC00420 with redirect_ready=1 on the first cycle → busy for exactly 1 cycle.
6. Exception taken, reset asserted in REDIRECT → next cycle redirect_valid=0, busy=0, wb_ex=0.
